// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/fetch stage feeding an IF/ID register from a combinational instruction ROM.
// Optional feature: define JUMP_SELF_HALT_EN to stop at a self-jump instead of looping on it.
module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0,
  parameter int PROG_LEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] read_address,
  input  logic [7:0]        instruction_in,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume,
  output logic [7:0]        if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              if_id_valid,
  output logic              halted
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HALT} state_t;

  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);
  // One extra bit so PROG_LEN == 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   PROG_LEN_W = (ADDR_W+1)'(PROG_LEN);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        if_id_instr_q;
  logic [ADDR_W-1:0] if_id_pc_q;
  logic              if_id_valid_q;
  logic              halted_q;

  logic              is_jump;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] next_pc_d;
  logic              pc_in_range;

  always_comb begin
    is_jump     = (instruction_in[7:6] == 2'b11);
    imm_ext     = {{(ADDR_W-6){instruction_in[5]}}, instruction_in[5:0]};
    next_pc_d   = is_jump ? (pc_q + ADDR_W'(1) + imm_ext) : (pc_q + ADDR_W'(1));
    pc_in_range = ({1'b0, pc_q} < PROG_LEN_W);
  end

`ifdef JUMP_SELF_HALT_EN
  logic self_jump;
  always_comb self_jump = is_jump && (next_pc_d == pc_q);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC_W;
      if_id_instr_q <= 8'h00;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          if_id_valid_q <= 1'b0;
          if (halt_req) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!pc_in_range || halt_req) begin
            state_q       <= S_HALT;
            halted_q      <= 1'b1;
            if_id_valid_q <= 1'b0;
          end else if (!stall) begin
            if_id_instr_q <= instruction_in;
            if_id_pc_q    <= pc_q;
            if_id_valid_q <= 1'b1;
            pc_q          <= next_pc_d;
`ifdef JUMP_SELF_HALT_EN
            // The self-jump is still issued once; only the following fetch stops.
            if (self_jump) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
`endif
          end
        end
        S_HALT: begin
          if_id_valid_q <= 1'b0;
          if (resume && !halt_req && pc_in_range) begin
            state_q  <= S_FETCH;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_HALT;
          halted_q      <= 1'b1;
          if_id_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign read_address = pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_valid  = if_id_valid_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (PROG_LEN=22), honours JUMP_SELF_HALT_EN.
module tb_fetch_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] read_address;
  logic [7:0]    instruction_in;
  logic          stall = 1'b0;
  logic          halt_req = 1'b0;
  logic          resume = 1'b0;
  logic [7:0]    if_id_instr;
  logic [AW-1:0] if_id_pc;
  logic          if_id_valid;
  logic          halted;

  logic [7:0] rom [256];

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] instr;
  } issue_t;

  issue_t exp_q[$];
  int total = 0;
  int bad = 0;

  fetch_unit #(.ADDR_W(AW), .RESET_PC(0), .PROG_LEN(22)) dut (
    .clk(clk), .reset_n(reset_n), .read_address(read_address),
    .instruction_in(instruction_in), .stall(stall), .halt_req(halt_req),
    .resume(resume), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .halted(halted)
  );

  always #5 clk = ~clk;
  assign instruction_in = rom[read_address];

  task automatic push_seq(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back({8'(i), rom[i]});
  endtask

  // One clock; a new issue is valid=1 after an edge where stall was low.
  task automatic step();
    logic s;
    issue_t e;
    s = stall;
    @(posedge clk);
    #1;
    if (if_id_valid && !s) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_issue: got pc=%0d instr=%02h, required no issue", if_id_pc, if_id_instr);
      end else begin
        e = exp_q.pop_front();
        if (if_id_pc !== e.pc || if_id_instr !== e.instr) begin
          bad++;
          $display("FAIL issue: got pc=%0d instr=%02h, required pc=%0d instr=%02h",
                   if_id_pc, if_id_instr, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d issues still missing after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    total++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 8'h00 || if_id_pc !== 8'h00 ||
        halted !== 1'b0 || read_address !== 8'h00) begin
      bad++;
      $display("FAIL %s: got valid=%b instr=%02h pc=%0d halted=%b addr=%0d, required 0 0 0 0 0",
               tag, if_id_valid, if_id_instr, if_id_pc, halted, read_address);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) rom[i] = {2'b01, 6'(i)};
    rom[0] = 8'h65;
    rom[1] = 8'h84;
    rom[19] = 8'hC1;
    rom[21] = 8'h45;
    #3;
    check_cleared("reset_state");
  endtask

  task automatic test_boot_seq();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push_seq(0, 1);
    step();
    total++;
    if (if_id_valid !== 1'b0) begin
      bad++;
      $display("FAIL boot_valid: got %b, required 0", if_id_valid);
    end
    step();
    step();
    drain(1);
  endtask

  task automatic test_jump();
    push_seq(2, 19);
    drain(30);
    total++;
    if (read_address !== 8'd21) begin
      bad++;
      $display("FAIL jump_target: got addr=%0d, required 21", read_address);
    end
    push_seq(21, 21);
    drain(2);
  endtask

  task automatic test_prog_end();
    step();
    total++;
    if (halted !== 1'b1 || if_id_valid !== 1'b0) begin
      bad++;
      $display("FAIL prog_end_halt: got halted=%b valid=%b, required 1 0", halted, if_id_valid);
    end
    resume = 1'b1;
    step();
    step();
    resume = 1'b0;
    total++;
    if (halted !== 1'b1 || read_address !== 8'd22) begin
      bad++;
      $display("FAIL resume_ignored: got halted=%b addr=%0d, required 1 22", halted, read_address);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    push_seq(0, 5);
    drain(10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (if_id_pc !== 8'd5 || if_id_instr !== rom[5] || if_id_valid !== 1'b1 || read_address !== 8'd6) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got pc=%0d instr=%02h valid=%b addr=%0d, required 5 %02h 1 6",
                 i, if_id_pc, if_id_instr, if_id_valid, read_address, rom[5]);
      end
    end
    stall = 1'b0;
    push_seq(6, 6);
    step();
    drain(1);
  endtask

  task automatic test_halt();
    push_seq(7, 7);
    drain(2);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    total++;
    if (halted !== 1'b1 || if_id_valid !== 1'b0 || read_address !== 8'd8) begin
      bad++;
      $display("FAIL halt_req: got halted=%b valid=%b addr=%0d, required 1 0 8", halted, if_id_valid, read_address);
    end
    step();
    resume = 1'b1;
    step();
    resume = 1'b0;
    total++;
    if (halted !== 1'b0 || if_id_valid !== 1'b0) begin
      bad++;
      $display("FAIL resume: got halted=%b valid=%b, required 0 0", halted, if_id_valid);
    end
    push_seq(8, 8);
    step();
    drain(1);
  endtask

  task automatic test_async_reset();
    push_seq(9, 13);
    drain(8);
    total++;
    if (read_address !== 8'd14) begin
      bad++;
      $display("FAIL pre_reset_pc: got addr=%0d, required 14", read_address);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_cleared("async_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    total++;
    if (if_id_valid !== 1'b0) begin
      bad++;
      $display("FAIL reboot_valid: got %b, required 0", if_id_valid);
    end
    push_seq(0, 0);
    step();
    drain(1);
  endtask

  task automatic test_self_jump();
    rom[10] = 8'hFF;
    do_reset();
    step();
    push_seq(0, 10);
    drain(15);
`ifdef JUMP_SELF_HALT_EN
    step();
    step();
    total++;
    if (halted !== 1'b1 || read_address !== 8'd10) begin
      bad++;
      $display("FAIL self_jump_halt: got halted=%b addr=%0d, required 1 10", halted, read_address);
    end
`else
    push_seq(10, 10);
    push_seq(10, 10);
    push_seq(10, 10);
    drain(3);
    total++;
    if (halted !== 1'b0 || read_address !== 8'd10) begin
      bad++;
      $display("FAIL self_jump_loop: got halted=%b addr=%0d, required 0 10", halted, read_address);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_jump();
    test_prog_end();
    test_stall();
    test_halt();
    test_async_reset();
    test_self_jump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- PC/fetch stage directly upstream of the 8-bit instruction ROM.
- Drives the ROM read address and captures the returned instruction into an IF/ID register.
- Resolves jumps (opcode 2'b11) in fetch; the decode/execute stage consumes the IF/ID outputs.

Parameters:
ADDR_W, 8, PC / read-address width; all PC arithmetic is modulo 2^ADDR_W.
RESET_PC, 0, PC value loaded on reset.
PROG_LEN, 32, number of valid ROM words; fetch at pc >= PROG_LEN halts.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
read_address  output  ADDR_W  ROM address = pc (combinational from PC register)
instruction_in  input  8  ROM data for read_address (combinational ROM)
stall  input  1  downstream hold; freezes PC and IF/ID
halt_req  input  1  request to stop fetching
resume  input  1  leave HALT and continue at current pc
if_id_instr  output  8  registered instruction
if_id_pc  output  ADDR_W  registered PC of if_id_instr
if_id_valid  output  1  if_id_instr is a real instruction
halted  output  1  high in HALT state

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, state=BOOT, if_id_instr=8'h00, if_id_pc=0, if_id_valid=0, halted=0.
- Opcode is instruction_in[7:6]. Jump when opcode==2'b11, with imm = instruction_in[5:0] (signed 6-bit).
- next_pc for a jump is pc+1+sext(imm). Otherwise next_pc is pc+1. Both are truncated to ADDR_W bits, so wrap 255->0 at ADDR_W=8.
- States:
  - BOOT: one cycle. Valid=0. pc holds. Goes to FETCH unconditionally, except halt_req=1 goes to HALT.
  - FETCH, pc >= PROG_LEN: no issue. if_id_valid<=0. Goes to HALT. pc holds.
  - FETCH, halt_req=1: goes to HALT. if_id_valid<=0. pc holds. halt_req has priority over stall and fetch.
  - FETCH, stall=1: pc, if_id_instr, if_id_pc and if_id_valid all hold.
  - FETCH, normal: if_id_instr<=instruction_in, if_id_pc<=pc, if_id_valid<=1, pc<=next_pc.
  - HALT: halted=1, if_id_valid=0, pc holds. resume=1 (with halt_req=0) goes to FETCH next cycle. Resume is honoured only if pc < PROG_LEN; otherwise the block stays in HALT.
- Latency: one cycle from read_address to if_id outputs. Jump target is fetched the cycle immediately after the jump is fetched, with no bubble.
- The jump instruction itself is issued with valid=1. Downstream treats it as a no-op.
- halted is registered: it asserts the cycle the state becomes HALT and deasserts the cycle the state leaves HALT.
- Reset mid-operation: all state clears immediately, independent of clk. The first issue occurs 2 cycles after reset_n rises (BOOT, then FETCH).

Optional Feature:
JUMP_SELF_HALT_EN
- Defined: in FETCH, a jump whose next_pc == pc (imm = 6'h3F) is issued normally (valid=1), then the state goes to HALT instead of looping.
- Undefined: the self-jump loops forever, issuing the same instruction every unstalled cycle.

Test Plan:
- Reset release, ROM[0]=8'h65, ROM[1]=8'h84: cycle 1 valid=0 (BOOT); cycle 2 if_id_instr=8'h65, if_id_pc=0; cycle 3 if_id_instr=8'h84, if_id_pc=1.
- ROM[19]=8'hC1, ROM[21]=8'h45: after pc 19 is issued, read_address=21; next issue is if_id_instr=8'h45, if_id_pc=21; pc 20 is never issued.
- stall=1 for 3 cycles while if_id_pc=5: if_id outputs and read_address are frozen; on release, the next issue is pc 6 with no duplicate and no skip.
- halt_req pulse at pc=8: next cycle halted=1, valid=0, read_address=8. resume=1 gives halted=0 and the next issue has if_id_pc=8.
- PROG_LEN=22, sequential run: after pc 21 is issued, halted=1 and resume is ignored. Jump 8'hFF at pc 10 (JUMP_SELF_HALT_EN defined): pc 10 is issued once, then halted=1.
- reset_n asserted mid-run between clock edges (pc=14): outputs clear immediately; after release, BOOT runs, then the first issue is if_id_pc=0.
